// File: rtl/baccarat_sequencer.sv
// -----------------------------------------------------------------------------
// baccarat_sequencer
//
// Control FSM for the baccarat datapath. Deals four cards in fixed order
// (player 1, dealer 1, player 2, dealer 2), applies the third-card rules to
// the running hand scores, then holds the win lights until reset.
//
// Ports
//   slow_clock        : sole clock, all state changes on the rising edge
//   reset             : synchronous, active-high reset (returns to IDLE)
//   pscore, dscore    : player / dealer hand score from the datapath (0-9)
//   pcard3            : player third-card rank (1=A .. 13=K, 0=empty)
//   load_pcard1..3    : one-cycle strobe, datapath loads that player card
//   load_dcard1..3    : one-cycle strobe, datapath loads that dealer card
//   player_win_light  : player wins (both lights on means a tie)
//   dealer_win_light  : dealer wins
//   done              : hand complete
// -----------------------------------------------------------------------------
module baccarat_sequencer (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] DEAL_P1 = 4'd1;
  localparam logic [3:0] DEAL_D1 = 4'd2;
  localparam logic [3:0] DEAL_P2 = 4'd3;
  localparam logic [3:0] DEAL_D2 = 4'd4;
  localparam logic [3:0] EVAL    = 4'd5;
  localparam logic [3:0] DEAL_P3 = 4'd6;
  localparam logic [3:0] BANK    = 4'd7;
  localparam logic [3:0] DEAL_D3 = 4'd8;
  localparam logic [3:0] RESULT  = 4'd9;

  logic [3:0] state;
  logic [3:0] next_state;

  // Banker rule once the player has drawn: face cards and tens count as 0.
  function automatic logic bank_draws(input logic [3:0] ds, input logic [3:0] card);
    logic [3:0] v;
    v = (card >= 4'd1 && card <= 4'd9) ? card : 4'd0;
    case (ds)
      4'd0, 4'd1, 4'd2: bank_draws = 1'b1;
      4'd3:             bank_draws = (v != 4'd8);
      4'd4:             bank_draws = (v >= 4'd2 && v <= 4'd7);
      4'd5:             bank_draws = (v >= 4'd4 && v <= 4'd7);
      4'd6:             bank_draws = (v >= 4'd6 && v <= 4'd7);
      default:          bank_draws = 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    next_state = state;
    case (state)
      IDLE:    next_state = DEAL_P1;
      DEAL_P1: next_state = DEAL_D1;
      DEAL_D1: next_state = DEAL_P2;
      DEAL_P2: next_state = DEAL_D2;
      DEAL_D2: next_state = EVAL;
      EVAL: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) next_state = RESULT;   // natural
        else if (pscore <= 4'd5)              next_state = DEAL_P3;
        else if (dscore <= 4'd5)              next_state = DEAL_D3;
        else                                  next_state = RESULT;
      end
      DEAL_P3: next_state = BANK;
      BANK:    next_state = bank_draws(dscore, pcard3) ? DEAL_D3 : RESULT;
      DEAL_D3: next_state = RESULT;
      RESULT:  next_state = RESULT;
      // Unused encodings recover to IDLE so the FSM can never lock up.
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Moore decode: each deal state drives exactly its own strobe.
  assign load_pcard1 = (state == DEAL_P1);
  assign load_dcard1 = (state == DEAL_D1);
  assign load_pcard2 = (state == DEAL_P2);
  assign load_dcard2 = (state == DEAL_D2);
  assign load_pcard3 = (state == DEAL_P3);
  assign load_dcard3 = (state == DEAL_D3);

  assign done             = (state == RESULT);
  assign player_win_light = done && (pscore >= dscore);
  assign dealer_win_light = done && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_baccarat_sequencer
//
// Scoreboard bench: the stimulus process builds the expected per-cycle output
// trace of each hand from the game rules and pushes one entry per cycle; a
// monitor on the falling edge pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_baccarat_sequencer;

  logic       slow_clock = 1'b0;
  logic       reset      = 1'b1;
  logic [3:0] pscore     = '0;
  logic [3:0] dscore     = '0;
  logic [3:0] pcard3     = '0;
  logic load_pcard1, load_pcard2, load_pcard3;
  logic load_dcard1, load_dcard2, load_dcard3;
  logic player_win_light, dealer_win_light, done;

  baccarat_sequencer dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .done             (done)
  );

  always #5 slow_clock = ~slow_clock;

  // Output vector: {p1,p2,p3,d1,d2,d3,player_light,dealer_light,done}
  localparam logic [8:0] O_P1 = 9'b100000000;
  localparam logic [8:0] O_P2 = 9'b010000000;
  localparam logic [8:0] O_P3 = 9'b001000000;
  localparam logic [8:0] O_D1 = 9'b000100000;
  localparam logic [8:0] O_D2 = 9'b000010000;
  localparam logic [8:0] O_D3 = 9'b000001000;
  localparam logic [8:0] O_PW = 9'b000000100;
  localparam logic [8:0] O_DW = 9'b000000010;
  localparam logic [8:0] O_DN = 9'b000000001;

  typedef struct {
    logic [8:0] vec;
    int         hand;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] trace[$];
  int         result_cycle;
  int         n_compared   = 0;
  int         n_mismatched = 0;
  int         hand_id      = 0;

  task automatic check(input string name, input int hand, input int cyc,
                       input logic [8:0] act, input logic [8:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s hand=%0d cycle=%0d got=%b expected=%b", name, hand, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared.
  always @(negedge slow_clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("outputs", e.hand, e.cyc,
            {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
             load_dcard3, player_win_light, dealer_win_light, done}, e.vec);
    end
  end

  // ---- reference model: game rules, producing the whole hand trace ----
  function automatic bit banker_hits(input int ds, input int card);
    int v;
    v = (card >= 1 && card <= 9) ? card : 0;
    if (ds <= 2) return 1;
    if (ds == 3) return v != 8;
    if (ds == 4) return v >= 2 && v <= 7;
    if (ds == 5) return v >= 4 && v <= 7;
    if (ds == 6) return v >= 6 && v <= 7;
    return 0;
  endfunction

  task automatic build_trace(input int ps, input int ds, input int card,
                             input int fps, input int fds, input int n_result);
    bit natural, player_draws, dealer_draws;
    logic [8:0] res;
    trace.delete();
    natural      = (ps >= 8) || (ds >= 8);
    player_draws = !natural && ps <= 5;
    if (natural)           dealer_draws = 0;
    else if (player_draws) dealer_draws = banker_hits(ds, card);
    else                   dealer_draws = ds <= 5;
    trace.push_back('0);                      // cycle 0: IDLE
    trace.push_back(O_P1);
    trace.push_back(O_D1);
    trace.push_back(O_P2);
    trace.push_back(O_D2);
    trace.push_back('0);                      // EVAL
    if (player_draws) begin
      trace.push_back(O_P3);
      trace.push_back('0);                    // BANK
    end
    if (dealer_draws) trace.push_back(O_D3);
    result_cycle = trace.size();
    res = O_DN;
    if (fps >= fds) res |= O_PW;
    if (fds >= fps) res |= O_DW;
    for (int i = 0; i < n_result; i++) trace.push_back(res);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge slow_clock);
    #1 reset = 1'b0;
  endtask

  // Runs one hand from cycle 0; if abort_at >= 0, reset is asserted during
  // that cycle and the task returns in the cycle after the reset edge.
  task automatic run_hand(input int ps, input int ds, input int card,
                          input int fps, input int fds, input int n_result,
                          input int abort_at);
    exp_t e;
    hand_id++;
    build_trace(ps, ds, card, fps, fds, n_result);
    for (int c = 0; c < trace.size(); c++) begin
      if (c < 5) begin
        pscore = 4'($urandom_range(0, 9));    // not yet meaningful
        dscore = 4'($urandom_range(0, 9));
      end else if (c < result_cycle) begin
        pscore = 4'(ps);
        dscore = 4'(ds);
      end else begin
        pscore = 4'(fps);
        dscore = 4'(fds);
      end
      pcard3 = 4'(card);
      e.vec = trace[c]; e.hand = hand_id; e.cyc = c;
      exp_q.push_back(e);
      if (c == abort_at) reset = 1'b1;
      @(posedge slow_clock);
      #1;
      if (c == abort_at) begin
        reset = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    do_reset();
    // Natural, held for 20 result cycles.
    run_hand(8, 3, 0, 8, 3, 20, -1);
    // Both draw, dealer wins.
    do_reset(); run_hand(4, 2, 9, 3, 7, 3, -1);
    // Banker stand table at dscore 6.
    do_reset(); run_hand(5, 6, 5, 2, 6, 3, -1);
    do_reset(); run_hand(5, 6, 7, 2, 9, 3, -1);
    // Face-card mapping at dscore 3.
    do_reset(); run_hand(2, 3, 12, 2, 5, 3, -1);
    do_reset(); run_hand(2, 3, 8, 0, 3, 3, -1);
    // Player stands, dealer draws, tie.
    do_reset(); run_hand(7, 5, 0, 7, 7, 3, -1);
    // Reset during DEAL_D1, then a full hand starting at cycle 0.
    do_reset(); run_hand(3, 1, 4, 6, 6, 3, 2);
    run_hand(6, 7, 0, 6, 7, 3, -1);
    // Reset during RESULT, then a full hand.
    do_reset(); run_hand(9, 1, 0, 9, 1, 5, 8);
    run_hand(1, 4, 13, 8, 4, 3, -1);
    // Randomized hands.
    for (int h = 0; h < 60; h++) begin
      do_reset();
      run_hand($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 13),
               $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 4), -1);
    end
    @(negedge slow_clock);
    #1;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
